// File: rtl/rv32i_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_pkg
// Shared widths and types for the RV32I out-of-order back end.
//   PU_ID_BW             - width of a processing-unit identifier
//   REG_FILE_BW          - architectural/physical register width
//   PHYS_REG_FILE_IDX_BW - physical register file index (producer tag) width
//   ROB_IDX_BW           - reorder-buffer index width
//   RS_ENTRY_T           - one reservation-station entry (operands + payload)
// ----------------------------------------------------------------------------
package rv32i_pkg;

    localparam int PU_ID_BW             = 2;
    localparam int REG_FILE_BW          = 32;
    localparam int PHYS_REG_FILE_IDX_BW = 6;
    localparam int ROB_IDX_BW           = 5;

    typedef struct packed {
        logic                            src1_value_vld;
        logic [REG_FILE_BW-1:0]          src1_value;
        logic [PHYS_REG_FILE_IDX_BW-1:0] src1_phys_rf_tag;
        logic                            src2_value_vld;
        logic [REG_FILE_BW-1:0]          src2_value;
        logic [PHYS_REG_FILE_IDX_BW-1:0] src2_phys_rf_tag;
        logic                            dst_phys_rf_vld;
        logic [PHYS_REG_FILE_IDX_BW-1:0] dst_phys_rf_tag;
        logic [REG_FILE_BW-1:0]          imm;
        logic [ROB_IDX_BW-1:0]           rob_idx;
    } RS_ENTRY_T;

    // True when the write-back bus is producing the register an operand waits on.
    function automatic logic snoop_hit(
        input logic                            write_back,
        input logic [PHYS_REG_FILE_IDX_BW-1:0] wr_idx,
        input logic [PHYS_REG_FILE_IDX_BW-1:0] tag
    );
        return write_back & (wr_idx == tag);
    endfunction

endpackage

// File: rtl/rv32i_age_matrix.sv
// ----------------------------------------------------------------------------
// rv32i_age_matrix
// Older-than matrix tracking allocation order of RS_DEPTH slots and picking
// the oldest slot among a request vector.
//   clk, rst  - clock, asynchronous active-high reset
//   alloc     - one-hot (or zero) slot being allocated this edge
//   req       - slots competing for selection
//   oldest    - one-hot oldest requesting slot (zero when req is zero)
// ----------------------------------------------------------------------------
module rv32i_age_matrix #(
    parameter int RS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RS_DEPTH-1:0] alloc,
    input  logic [RS_DEPTH-1:0] req,
    output logic [RS_DEPTH-1:0] oldest
);

    // older[i][j] = 1: slot i was allocated before slot j.
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older;
    logic [RS_DEPTH-1:0]               blocked;

    // A new allocation is younger than every other slot: clear its row,
    // set its column. Stale bits of freed slots are overwritten on reuse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            older <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (alloc[i]) begin
                        older[i][j] <= 1'b0;
                    end else if (alloc[j]) begin
                        older[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        blocked = '0;
        oldest  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if ((j != i) && req[j] && older[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
            oldest[i] = req[i] & ~blocked[i];
        end
    end

endmodule

// File: rtl/rv32i_rsrv_sttn.sv
// ----------------------------------------------------------------------------
// rv32i_rsrv_sttn
// Reservation station for one processing unit: holds dispatched instructions
// until both operands are valid (snooping the write-back bus), then moves the
// oldest ready one into an issue register handed to the PU.
//   clk, rst                  - clock, asynchronous active-high reset
//   i_dispatch, i_pu_id       - dispatch strobe and target PU
//   i_src*_value_vld/value/.. - operand values or producer tags
//   i_dst_*, i_imm, i_rob_idx - payload carried to the PU
//   i_write_back, i_phys_rf_wr_idx, i_wdata - write-back snoop bus
//   o_full                    - all entries occupied
//   o_issue, i_pu_rdy         - issue register valid / PU accepts it
//   o_src*_value, o_dst_*, o_imm, o_rob_idx - issue register payload
// ----------------------------------------------------------------------------
module rv32i_rsrv_sttn
    import rv32i_pkg::*;
#(
    parameter int                  RS_DEPTH = 4,
    parameter logic [PU_ID_BW-1:0] PU_ID    = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_dispatch,
    input  logic [PU_ID_BW-1:0]             i_pu_id,
    input  logic                            i_src1_value_vld,
    input  logic                            i_src2_value_vld,
    input  logic [REG_FILE_BW-1:0]          i_src1_value,
    input  logic [REG_FILE_BW-1:0]          i_src2_value,
    input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_src1_phys_rf_tag,
    input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_src2_phys_rf_tag,
    input  logic                            i_dst_phys_rf_vld,
    input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_dst_phys_rf_tag,
    input  logic [REG_FILE_BW-1:0]          i_imm,
    input  logic [ROB_IDX_BW-1:0]           i_rob_idx,
    input  logic                            i_write_back,
    input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_phys_rf_wr_idx,
    input  logic [REG_FILE_BW-1:0]          i_wdata,
    output logic                            o_full,
    output logic                            o_issue,
    input  logic                            i_pu_rdy,
    output logic [REG_FILE_BW-1:0]          o_src1_value,
    output logic [REG_FILE_BW-1:0]          o_src2_value,
    output logic                            o_dst_phys_rf_vld,
    output logic [PHYS_REG_FILE_IDX_BW-1:0] o_dst_phys_rf_tag,
    output logic [REG_FILE_BW-1:0]          o_imm,
    output logic [ROB_IDX_BW-1:0]           o_rob_idx
);

    RS_ENTRY_T                       ent [RS_DEPTH];
    logic [RS_DEPTH-1:0]             ent_vld;
    logic [RS_DEPTH-1:0]             free_oh;
    logic [RS_DEPTH-1:0]             alloc_oh;
    logic [RS_DEPTH-1:0]             rdy_vec;
    logic [RS_DEPTH-1:0]             sel_oh;
    logic                            found_free;
    logic                            accept;
    logic                            load_en;
    logic                            take;
    RS_ENTRY_T                       new_ent;

    logic [REG_FILE_BW-1:0]          sel_src1;
    logic [REG_FILE_BW-1:0]          sel_src2;
    logic                            sel_dst_vld;
    logic [PHYS_REG_FILE_IDX_BW-1:0] sel_dst_tag;
    logic [REG_FILE_BW-1:0]          sel_imm;
    logic [ROB_IDX_BW-1:0]           sel_rob;

    // Capacity is judged on current occupancy only; an entry leaving for the
    // issue register this cycle is not offered to dispatch until next cycle.
    assign o_full   = &ent_vld;
    assign accept   = i_dispatch & (i_pu_id == PU_ID) & ~o_full;
    assign alloc_oh = accept ? free_oh : '0;
    assign load_en  = ~o_issue | i_pu_rdy;
    assign take     = load_en & (|rdy_vec);

    always_comb begin
        free_oh    = '0;
        found_free = 1'b0;
        rdy_vec    = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!ent_vld[i] && !found_free) begin
                free_oh[i] = 1'b1;
                found_free = 1'b1;
            end
            rdy_vec[i] = ent_vld[i] & ent[i].src1_value_vld & ent[i].src2_value_vld;
        end
    end

    // Incoming operands also snoop the write-back bus so a result produced on
    // the accept edge is not missed.
    always_comb begin
        new_ent                  = '0;
        new_ent.src1_value_vld   = i_src1_value_vld |
                                   snoop_hit(i_write_back, i_phys_rf_wr_idx, i_src1_phys_rf_tag);
        new_ent.src1_value       = i_src1_value_vld ? i_src1_value : i_wdata;
        new_ent.src1_phys_rf_tag = i_src1_phys_rf_tag;
        new_ent.src2_value_vld   = i_src2_value_vld |
                                   snoop_hit(i_write_back, i_phys_rf_wr_idx, i_src2_phys_rf_tag);
        new_ent.src2_value       = i_src2_value_vld ? i_src2_value : i_wdata;
        new_ent.src2_phys_rf_tag = i_src2_phys_rf_tag;
        new_ent.dst_phys_rf_vld  = i_dst_phys_rf_vld;
        new_ent.dst_phys_rf_tag  = i_dst_phys_rf_tag;
        new_ent.imm              = i_imm;
        new_ent.rob_idx          = i_rob_idx;
    end

    rv32i_age_matrix #(
        .RS_DEPTH (RS_DEPTH)
    ) u_age (
        .clk    (clk),
        .rst    (rst),
        .alloc  (alloc_oh),
        .req    (rdy_vec),
        .oldest (sel_oh)
    );

    always_comb begin
        sel_src1    = '0;
        sel_src2    = '0;
        sel_dst_vld = 1'b0;
        sel_dst_tag = '0;
        sel_imm     = '0;
        sel_rob     = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_src1    = ent[i].src1_value;
                sel_src2    = ent[i].src2_value;
                sel_dst_vld = ent[i].dst_phys_rf_vld;
                sel_dst_tag = ent[i].dst_phys_rf_tag;
                sel_imm     = ent[i].imm;
                sel_rob     = ent[i].rob_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    ent_vld[i] <= 1'b1;
                    ent[i]     <= new_ent;
                end else begin
                    if (take && sel_oh[i]) begin
                        ent_vld[i] <= 1'b0;
                    end
                    if (ent_vld[i] && !ent[i].src1_value_vld &&
                        snoop_hit(i_write_back, i_phys_rf_wr_idx, ent[i].src1_phys_rf_tag)) begin
                        ent[i].src1_value_vld <= 1'b1;
                        ent[i].src1_value     <= i_wdata;
                    end
                    if (ent_vld[i] && !ent[i].src2_value_vld &&
                        snoop_hit(i_write_back, i_phys_rf_wr_idx, ent[i].src2_phys_rf_tag)) begin
                        ent[i].src2_value_vld <= 1'b1;
                        ent[i].src2_value     <= i_wdata;
                    end
                end
            end
        end
    end

    // Issue register: payload is only rewritten on a load, so it holds
    // steady while the PU stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_issue           <= 1'b0;
            o_src1_value      <= '0;
            o_src2_value      <= '0;
            o_dst_phys_rf_vld <= 1'b0;
            o_dst_phys_rf_tag <= '0;
            o_imm             <= '0;
            o_rob_idx         <= '0;
        end else if (load_en) begin
            o_issue <= take;
            if (take) begin
                o_src1_value      <= sel_src1;
                o_src2_value      <= sel_src2;
                o_dst_phys_rf_vld <= sel_dst_vld;
                o_dst_phys_rf_tag <= sel_dst_tag;
                o_imm             <= sel_imm;
                o_rob_idx         <= sel_rob;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_rsrv_sttn.sv
// ----------------------------------------------------------------------------
// tb_rv32i_rsrv_sttn
// Directed scenarios followed by random traffic, every cycle compared with a
// queue-based model of the station (entries kept in acceptance order).
// ----------------------------------------------------------------------------
module tb_rv32i_rsrv_sttn;
    import rv32i_pkg::*;

    localparam int                  DEPTH = 4;
    localparam logic [PU_ID_BW-1:0] MY_PU = 2'd1;

    logic                            clk = 1'b0;
    logic                            rst = 1'b0;
    logic                            i_dispatch;
    logic [PU_ID_BW-1:0]             i_pu_id;
    logic                            i_src1_value_vld, i_src2_value_vld;
    logic [REG_FILE_BW-1:0]          i_src1_value, i_src2_value;
    logic [PHYS_REG_FILE_IDX_BW-1:0] i_src1_phys_rf_tag, i_src2_phys_rf_tag;
    logic                            i_dst_phys_rf_vld;
    logic [PHYS_REG_FILE_IDX_BW-1:0] i_dst_phys_rf_tag;
    logic [REG_FILE_BW-1:0]          i_imm;
    logic [ROB_IDX_BW-1:0]           i_rob_idx;
    logic                            i_write_back;
    logic [PHYS_REG_FILE_IDX_BW-1:0] i_phys_rf_wr_idx;
    logic [REG_FILE_BW-1:0]          i_wdata;
    logic                            o_full, o_issue, i_pu_rdy;
    logic [REG_FILE_BW-1:0]          o_src1_value, o_src2_value;
    logic                            o_dst_phys_rf_vld;
    logic [PHYS_REG_FILE_IDX_BW-1:0] o_dst_phys_rf_tag;
    logic [REG_FILE_BW-1:0]          o_imm;
    logic [ROB_IDX_BW-1:0]           o_rob_idx;

    rv32i_rsrv_sttn #(
        .RS_DEPTH (DEPTH),
        .PU_ID    (MY_PU)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_dispatch         (i_dispatch),
        .i_pu_id            (i_pu_id),
        .i_src1_value_vld   (i_src1_value_vld),
        .i_src2_value_vld   (i_src2_value_vld),
        .i_src1_value       (i_src1_value),
        .i_src2_value       (i_src2_value),
        .i_src1_phys_rf_tag (i_src1_phys_rf_tag),
        .i_src2_phys_rf_tag (i_src2_phys_rf_tag),
        .i_dst_phys_rf_vld  (i_dst_phys_rf_vld),
        .i_dst_phys_rf_tag  (i_dst_phys_rf_tag),
        .i_imm              (i_imm),
        .i_rob_idx          (i_rob_idx),
        .i_write_back       (i_write_back),
        .i_phys_rf_wr_idx   (i_phys_rf_wr_idx),
        .i_wdata            (i_wdata),
        .o_full             (o_full),
        .o_issue            (o_issue),
        .i_pu_rdy           (i_pu_rdy),
        .o_src1_value       (o_src1_value),
        .o_src2_value       (o_src2_value),
        .o_dst_phys_rf_vld  (o_dst_phys_rf_vld),
        .o_dst_phys_rf_tag  (o_dst_phys_rf_tag),
        .o_imm              (o_imm),
        .o_rob_idx          (o_rob_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                            s1v;
        logic [REG_FILE_BW-1:0]          s1;
        logic [PHYS_REG_FILE_IDX_BW-1:0] t1;
        logic                            s2v;
        logic [REG_FILE_BW-1:0]          s2;
        logic [PHYS_REG_FILE_IDX_BW-1:0] t2;
        logic                            dv;
        logic [PHYS_REG_FILE_IDX_BW-1:0] dt;
        logic [REG_FILE_BW-1:0]          imm;
        logic [ROB_IDX_BW-1:0]           rob;
    } ref_t;

    ref_t rq[$];
    logic m_iss;
    ref_t m_out;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        m_iss = 1'b0;
        m_out = '{default: '0};
    endtask

    // Next state of the station for the edge about to come, from current inputs.
    task automatic model_step();
        int   k;
        bit   acc;
        bit   ld;
        ref_t ne;
        acc = i_dispatch && (i_pu_id == MY_PU) && (rq.size() < DEPTH);
        ld  = !m_iss || i_pu_rdy;
        k   = -1;
        for (int n = 0; n < rq.size(); n++) begin
            if (k < 0 && rq[n].s1v && rq[n].s2v) k = n;
        end
        if (i_write_back) begin
            for (int n = 0; n < rq.size(); n++) begin
                if (!rq[n].s1v && rq[n].t1 == i_phys_rf_wr_idx) begin
                    rq[n].s1v = 1'b1; rq[n].s1 = i_wdata;
                end
                if (!rq[n].s2v && rq[n].t2 == i_phys_rf_wr_idx) begin
                    rq[n].s2v = 1'b1; rq[n].s2 = i_wdata;
                end
            end
        end
        if (ld) begin
            if (k >= 0) begin
                m_out = rq[k];
                rq.delete(k);
                m_iss = 1'b1;
            end else begin
                m_iss = 1'b0;
            end
        end
        if (acc) begin
            ne.t1  = i_src1_phys_rf_tag;
            ne.t2  = i_src2_phys_rf_tag;
            ne.s1v = i_src1_value_vld || (i_write_back && i_phys_rf_wr_idx == ne.t1);
            ne.s1  = i_src1_value_vld ? i_src1_value : i_wdata;
            ne.s2v = i_src2_value_vld || (i_write_back && i_phys_rf_wr_idx == ne.t2);
            ne.s2  = i_src2_value_vld ? i_src2_value : i_wdata;
            ne.dv  = i_dst_phys_rf_vld;
            ne.dt  = i_dst_phys_rf_tag;
            ne.imm = i_imm;
            ne.rob = i_rob_idx;
            rq.push_back(ne);
        end
    endtask

    task automatic compare_all();
        chk("full", 64'(o_full), 64'(rq.size() == DEPTH));
        chk("issue", 64'(o_issue), 64'(m_iss));
        if (m_iss) begin
            chk("src1", 64'(o_src1_value), 64'(m_out.s1));
            chk("src2", 64'(o_src2_value), 64'(m_out.s2));
            chk("dst_vld", 64'(o_dst_phys_rf_vld), 64'(m_out.dv));
            chk("dst_tag", 64'(o_dst_phys_rf_tag), 64'(m_out.dt));
            chk("imm", 64'(o_imm), 64'(m_out.imm));
            chk("rob", 64'(o_rob_idx), 64'(m_out.rob));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_idle();
        i_dispatch         = 1'b0;
        i_pu_id            = MY_PU;
        i_src1_value_vld   = 1'b0;
        i_src2_value_vld   = 1'b0;
        i_src1_value       = '0;
        i_src2_value       = '0;
        i_src1_phys_rf_tag = '0;
        i_src2_phys_rf_tag = '0;
        i_dst_phys_rf_vld  = 1'b0;
        i_dst_phys_rf_tag  = '0;
        i_imm              = '0;
        i_rob_idx          = '0;
        i_write_back       = 1'b0;
        i_phys_rf_wr_idx   = '0;
        i_wdata            = '0;
    endtask

    task automatic set_disp(input logic v1, input logic [31:0] d1, input logic [5:0] t1,
                            input logic v2, input logic [31:0] d2, input logic [5:0] t2,
                            input logic [4:0] rob);
        i_dispatch         = 1'b1;
        i_pu_id            = MY_PU;
        i_src1_value_vld   = v1;
        i_src1_value       = d1;
        i_src1_phys_rf_tag = t1;
        i_src2_value_vld   = v2;
        i_src2_value       = d2;
        i_src2_phys_rf_tag = t2;
        i_dst_phys_rf_vld  = 1'b1;
        i_dst_phys_rf_tag  = {1'b1, rob};
        i_imm              = 32'h100 + 32'(rob);
        i_rob_idx          = rob;
    endtask

    task automatic set_wb(input logic [5:0] idx, input logic [31:0] d);
        i_write_back     = 1'b1;
        i_phys_rf_wr_idx = idx;
        i_wdata          = d;
    endtask

    initial begin
        set_idle();
        i_pu_rdy = 1'b1;
        model_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_full", 64'(o_full), 64'd0);
        chk("rst_issue", 64'(o_issue), 64'd0);
        chk("rst_src1", 64'(o_src1_value), 64'd0);
        chk("rst_src2", 64'(o_src2_value), 64'd0);
        chk("rst_dst", 64'({o_dst_phys_rf_vld, o_dst_phys_rf_tag}), 64'd0);
        chk("rst_imm_rob", 64'({o_imm, o_rob_idx}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Minimum latency with both operands valid.
        set_disp(1, 32'd5, 0, 1, 32'd7, 0, 5'd3);
        cycle();
        chk("d033_early", 64'(o_issue), 64'd0);
        set_idle();
        cycle();
        chk("d033_issue", 64'(o_issue), 64'd1);
        chk("d033_src1", 64'(o_src1_value), 64'd5);
        chk("d033_src2", 64'(o_src2_value), 64'd7);
        chk("d033_rob", 64'(o_rob_idx), 64'd3);
        cycle();

        // Operand woken by a later write-back.
        set_disp(0, 32'd0, 6'd9, 1, 32'd3, 0, 5'd4);
        cycle();
        set_idle();
        cycle();
        cycle();
        set_wb(6'd9, 32'hAA);
        cycle();
        set_idle();
        chk("d034_wait", 64'(o_issue), 64'd0);
        cycle();
        chk("d034_issue", 64'(o_issue), 64'd1);
        chk("d034_src1", 64'(o_src1_value), 64'hAA);
        cycle();

        // Write-back on the accept edge.
        set_disp(1, 32'h11, 0, 0, 32'd0, 6'd12, 5'd6);
        set_wb(6'd12, 32'h55);
        cycle();
        set_idle();
        cycle();
        chk("d035_issue", 64'(o_issue), 64'd1);
        chk("d035_src2", 64'(o_src2_value), 64'h55);
        cycle();

        // Full station, out-of-order readiness, dispatch blocked while full.
        set_disp(0, 0, 6'd3, 1, 32'd1, 0, 5'd10); cycle();
        set_disp(0, 0, 6'd7, 1, 32'd1, 0, 5'd11); cycle();
        set_disp(0, 0, 6'd4, 1, 32'd1, 0, 5'd12); cycle();
        set_disp(0, 0, 6'd7, 1, 32'd1, 0, 5'd13); cycle();
        chk("d036_full", 64'(o_full), 64'd1);
        set_disp(1, 32'd1, 0, 1, 32'd1, 0, 5'd15);
        cycle();
        chk("d036_full_blk", 64'(o_full), 64'd1);
        set_wb(6'd4, 32'hC4);
        cycle();
        chk("d036_full_c", 64'(o_full), 64'd1);
        chk("d036_noiss", 64'(o_issue), 64'd0);
        set_wb(6'd3, 32'hA3);
        cycle();
        chk("d036_c_iss", 64'(o_issue), 64'd1);
        chk("d036_c_rob", 64'(o_rob_idx), 64'd12);
        chk("d036_c_src1", 64'(o_src1_value), 64'hC4);
        chk("d036_notfull", 64'(o_full), 64'd0);
        set_idle();
        cycle();
        chk("d036_a_rob", 64'(o_rob_idx), 64'd10);
        chk("d036_a_src1", 64'(o_src1_value), 64'hA3);
        set_wb(6'd7, 32'h77);
        cycle();
        set_idle();
        cycle();
        chk("d036_b_rob", 64'(o_rob_idx), 64'd11);
        cycle();
        chk("d036_d_rob", 64'(o_rob_idx), 64'd13);
        cycle();

        // Stall holds the payload, then back-to-back drain.
        i_pu_rdy = 1'b0;
        set_disp(1, 32'h21, 0, 1, 32'h31, 0, 5'd20); cycle();
        set_disp(1, 32'h22, 0, 1, 32'h32, 0, 5'd21); cycle();
        set_disp(1, 32'h23, 0, 1, 32'h33, 0, 5'd22); cycle();
        set_idle();
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("d037_hold_rob", 64'(o_rob_idx), 64'd20);
            chk("d037_hold_src1", 64'(o_src1_value), 64'h21);
        end
        i_pu_rdy = 1'b1;
        cycle();
        chk("d037_b2b_1", 64'({o_issue, o_rob_idx}), 64'({1'b1, 5'd21}));
        cycle();
        chk("d037_b2b_2", 64'({o_issue, o_rob_idx}), 64'({1'b1, 5'd22}));
        cycle();

        // Reset in the middle of traffic.
        i_pu_rdy = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            set_disp(1, 32'(n), 0, 1, 32'(n), 0, 5'(n));
            cycle();
        end
        set_idle();
        chk("d038_pre_iss", 64'(o_issue), 64'd1);
        rst = 1'b1;
        #1;
        chk("d038_issue", 64'(o_issue), 64'd0);
        chk("d038_full", 64'(o_full), 64'd0);
        chk("d038_payload", 64'({o_src1_value, o_rob_idx}), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        i_pu_rdy = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk("d038_quiet", 64'(o_issue), 64'd0);
        end

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            i_dispatch         = ($urandom_range(0, 99) < 60);
            i_pu_id            = ($urandom_range(0, 1) == 1) ? MY_PU : PU_ID_BW'($urandom);
            i_src1_value_vld   = ($urandom_range(0, 1) == 1);
            i_src2_value_vld   = ($urandom_range(0, 1) == 1);
            i_src1_value       = REG_FILE_BW'($urandom);
            i_src2_value       = REG_FILE_BW'($urandom);
            i_src1_phys_rf_tag = PHYS_REG_FILE_IDX_BW'($urandom_range(0, 15));
            i_src2_phys_rf_tag = PHYS_REG_FILE_IDX_BW'($urandom_range(0, 15));
            i_dst_phys_rf_vld  = ($urandom_range(0, 1) == 1);
            i_dst_phys_rf_tag  = PHYS_REG_FILE_IDX_BW'($urandom);
            i_imm              = REG_FILE_BW'($urandom);
            i_rob_idx          = ROB_IDX_BW'($urandom);
            i_write_back       = ($urandom_range(0, 99) < 40);
            i_phys_rf_wr_idx   = PHYS_REG_FILE_IDX_BW'($urandom_range(0, 15));
            i_wdata            = REG_FILE_BW'($urandom);
            i_pu_rdy           = ($urandom_range(0, 99) < 70);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
